pulse_gen_mc: RTL and testbench

PULSE_GEN_MC -- requirements
Module: pulse_gen_mc

---
 rtl/pulse_gen_mc.sv | 100 ++++++++++
 tb/tb_pulse_gen_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_mc.sv
// Multi-channel edge-triggered pulse generator: each channel turns a qualified
// trigger edge into a pulse_len-cycle pulse, with optional retrigger and a done strobe.
module pulse_gen_mc #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [NCH-1:0]     trig_in,
    input  logic [2*NCH-1:0]   edge_mode,
    input  logic [CNT_W-1:0]   pulse_len,
    input  logic               retrig,
    output logic [NCH-1:0]     pulse_out,
    output logic [NCH-1:0]     done,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01
    } state_e;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   prev_d;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;
    logic [NCH-1:0]   edge_hit;
    logic [NCH-1:0]   active;
    logic             len_ok;

    always_comb begin
        prev_d   = trig_in;
        rise     = trig_in & ~prev_q;
        fall     = ~trig_in & prev_q;
        len_ok   = (pulse_len != '0);
        edge_hit = '0;
        active   = '0;
        done     = '0;
        for (int i = 0; i < NCH; i++) begin
            edge_hit[i] = (edge_mode[2*i] & rise[i]) | (edge_mode[2*i+1] & fall[i]);
            active[i]   = (state_q[i] == ST_PULSE);
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            // clr beats any edge on the same cycle; the counter holds remaining cycles minus one
            if (clr) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (edge_hit[i] && len_ok) begin
                            state_d[i] = ST_PULSE;
                            cnt_d[i]   = pulse_len - 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (retrig && edge_hit[i] && len_ok) begin
                            cnt_d[i] = pulse_len - 1'b1;
                        end else if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end else begin
                            state_d[i] = ST_IDLE;
                            done[i]    = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q <= prev_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign pulse_out = ACTIVE_LOW ? ~active : active;
    assign busy      = |active;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Bench for pulse_gen_mc: directed scenarios plus random traffic, checked against
// a remaining-cycles model per channel; a second ACTIVE_LOW=1 instance shares the inputs.
module tb_pulse_gen_mc;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [NCH-1:0]   trig_in;
    logic [2*NCH-1:0] edge_mode;
    logic [CNT_W-1:0] pulse_len;
    logic             retrig;
    logic [NCH-1:0]   pulse_out, done, pulse_out_al, done_al;
    logic             busy, busy_al;

    int checks = 0;
    int errors = 0;

    // Model: remaining active cycles per channel, plus its own copy of the last trigger level.
    int             rem      [NCH];
    logic [NCH-1:0] m_prev;
    int             act_cnt  [NCH];
    int             done_cnt [NCH];

    pulse_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .trig_in(trig_in), .edge_mode(edge_mode),
        .pulse_len(pulse_len), .retrig(retrig), .pulse_out(pulse_out), .done(done), .busy(busy)
    );

    pulse_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .clr(clr), .trig_in(trig_in), .edge_mode(edge_mode),
        .pulse_len(pulse_len), .retrig(retrig), .pulse_out(pulse_out_al), .done(done_al), .busy(busy_al)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_edge(input int i);
        bit r, f;
        r = trig_in[i] && !m_prev[i];
        f = !trig_in[i] && m_prev[i];
        return (edge_mode[2*i] && r) || (edge_mode[2*i+1] && f);
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NCH; i++) begin
            act_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
    endtask

    // Check outputs on the falling edge, advance the model, return 1 unit after the rising edge.
    task automatic tick(input string tag);
        logic [NCH-1:0] po, dn;
        bit             ev;
        bit             len_ok;
        @(negedge clk);
        len_ok = (pulse_len != 0);
        for (int i = 0; i < NCH; i++) begin
            ev    = model_edge(i);
            po[i] = !rst && rem[i] > 0;
            dn[i] = !rst && !clr && rem[i] == 1 && !(retrig && ev && len_ok);
        end
        check_vec({tag, " pulse_out"}, pulse_out, po);
        check_vec({tag, " done"}, done, dn);
        check_vec({tag, " busy"}, {{(NCH-1){1'b0}}, busy}, {{(NCH-1){1'b0}}, |po});
        check_vec({tag, " pulse_out_al"}, pulse_out_al, ~po);
        for (int i = 0; i < NCH; i++) begin
            act_cnt[i]  += int'(pulse_out[i]);
            done_cnt[i] += int'(done[i]);
        end
        for (int i = 0; i < NCH; i++) begin
            ev = model_edge(i);
            if (rst || clr)        rem[i] = 0;
            else if (rem[i] == 0)  rem[i] = (ev && len_ok) ? int'(pulse_len) : 0;
            else if (retrig && ev && len_ok) rem[i] = int'(pulse_len);
            else                   rem[i] = rem[i] - 1;
        end
        m_prev = rst ? '0 : trig_in;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, " pulse_out"}, pulse_out, '0);
        check_vec({tag, " pulse_out_al"}, pulse_out_al, '1);
        check_vec({tag, " done"}, done, '0);
        check_vec({tag, " busy"}, {{(NCH-1){1'b0}}, busy}, '0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; trig_in = '0; edge_mode = '0; pulse_len = '0; retrig = 1'b0;
        m_prev = '0;
        for (int i = 0; i < NCH; i++) rem[i] = 0;
        clear_counts();
        #1;
        check_reset_outputs("reset");
        run("reset", 2);
        rst = 1'b0;

        // ch0 rising, 10-cycle pulse
        edge_mode = 8'b00_00_00_01; pulse_len = 8'd10;
        run("idle", 2);
        clear_counts();
        trig_in[0] = 1'b1;
        run("ch0 len10", 14);
        check_int("ch0 len10 active", act_cnt[0], 10);
        check_int("ch0 len10 done", done_cnt[0], 1);
        trig_in[0] = 1'b0;

        // ch1 falling only, then both edges
        edge_mode = 8'b00_00_10_00; pulse_len = 8'd3;
        trig_in[1] = 1'b1;
        run("ch1 setup", 2);
        clear_counts();
        trig_in[1] = 1'b0;
        run("ch1 fall", 6);
        check_int("ch1 fall active", act_cnt[1], 3);
        check_int("ch1 fall done", done_cnt[1], 1);
        clear_counts();
        trig_in[1] = 1'b1;
        run("ch1 rise ignored", 5);
        check_int("ch1 rise ignored active", act_cnt[1], 0);
        edge_mode = 8'b00_00_11_00;
        clear_counts();
        trig_in[1] = 1'b0;
        run("ch1 both a", 6);
        trig_in[1] = 1'b1;
        run("ch1 both b", 6);
        check_int("ch1 both active", act_cnt[1], 6);
        check_int("ch1 both done", done_cnt[1], 2);
        trig_in[1] = 1'b0;

        // retrigger at pulse cycle 3: retrig=1 extends, retrig=0 ignores (and len change mid-pulse is ignored)
        edge_mode = 8'b00_00_00_01; pulse_len = 8'd5;
        for (int r = 1; r >= 0; r--) begin
            retrig = r[0];
            trig_in[0] = 1'b0;
            run("retrig settle", 3);
            clear_counts();
            trig_in[0] = 1'b1;
            tick("retrig detect");
            trig_in[0] = 1'b0;
            run("retrig cycle1-2", 2);
            if (r == 0) pulse_len = 8'd9;
            trig_in[0] = 1'b1;
            run("retrig tail", 9);
            check_int(r ? "retrig1 active" : "retrig0 active", act_cnt[0], r ? 8 : 5);
            check_int(r ? "retrig1 done" : "retrig0 done", done_cnt[0], 1);
            pulse_len = 8'd5;
        end
        retrig = 1'b0;

        // zero length is ignored; 255 runs full length without wrapping
        trig_in[0] = 1'b0; pulse_len = 8'd0;
        run("len0 settle", 2);
        clear_counts();
        trig_in[0] = 1'b1;
        run("len0", 4);
        check_int("len0 active", act_cnt[0], 0);
        check_int("len0 done", done_cnt[0], 0);
        trig_in[0] = 1'b0; pulse_len = 8'd255;
        run("len255 settle", 2);
        clear_counts();
        trig_in[0] = 1'b1;
        run("len255", 260);
        check_int("len255 active", act_cnt[0], 255);
        check_int("len255 done", done_cnt[0], 1);
        trig_in = '0;

        // clr during pulse with a concurrent ch2 edge
        edge_mode = 8'b00_01_00_01; pulse_len = 8'd6;
        run("clr settle", 2);
        clear_counts();
        trig_in[0] = 1'b1;
        run("clr pulse", 2);
        clr = 1'b1; trig_in[2] = 1'b1;
        tick("clr cycle");
        clr = 1'b0;
        run("clr after", 8);
        check_int("clr ch0 active", act_cnt[0], 2);
        check_int("clr ch0 done", done_cnt[0], 0);
        check_int("clr ch2 active", act_cnt[2], 0);
        trig_in = '0;

        // async reset mid-pulse, then trig_in held high through release
        pulse_len = 8'd20; edge_mode = 8'b00_00_00_01;
        run("rst settle", 2);
        clear_counts();
        trig_in[0] = 1'b1;
        run("rst pulse", 4);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst mid");
        run("rst held", 2);
        check_int("rst mid done", done_cnt[0], 0);
        rst = 1'b0;
        clear_counts();
        run("rst release", 24);
        check_int("rst release active", act_cnt[0], 20);
        trig_in = '0;
        run("rst drain", 2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 2) == 0) trig_in[i] = ~trig_in[i];
            if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_len = 8'($urandom_range(0, 7));
            retrig = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 24) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            tick("random");
        end
        rst = 1'b0; clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
